uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter among N_REQ requesters.
- Each requester asks for a burst of 1..2^LEN_W-1 bytes. The arbiter grants one requester at a time and drives trmt/tx_data to the UART transmitter one byte per frame. It uses the transmitter's sticky tx_done to pace the bytes.
- Sits between the command/telemetry sources and the shared UART transmitter; the baud divisor is wired to the transmitter separately.

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter among N_REQ
// byte-burst requesters. One byte in flight at a time, paced by tx_done.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*LEN_W-1:0]   req_len,
    input  logic [N_REQ*8-1:0]       req_data,
    output logic [N_REQ-1:0]         byte_ack,
    output logic [N_REQ-1:0]         burst_done,
    output logic [N_REQ-1:0]         grant,
    output logic                     busy,
    output logic                     trmt,
    output logic [7:0]               tx_data,
    input  logic                     tx_done
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned SUM_W  = IDX_W + 1;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        GUARD  = 2'd2,
        WAIT   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    logic [N_REQ-1:0]   grant_d;
    logic [N_REQ-1:0]   byte_ack_d;
    logic [N_REQ-1:0]   burst_done_d;
    logic               trmt_d;
    logic               busy_d;
    logic [BYTE_W-1:0]  tx_data_d;

    logic [LEN_W-1:0]   len_lane  [N_REQ];
    logic [BYTE_W-1:0]  data_lane [N_REQ];

    logic               win_found_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic [SUM_W-1:0]   cand_c;

    // Unpack the per-requester length and data lanes
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
        assign len_lane[gi]  = req_len[gi*LEN_W +: LEN_W];
        assign data_lane[gi] = req_data[gi*BYTE_W +: BYTE_W];
    end

    // Rotating priority search: first set req bit at or above ptr, with wrap
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand_c = {1'b0, ptr_q} + SUM_W'(k);
            if (cand_c >= SUM_W'(N_REQ)) begin
                cand_c = cand_c - SUM_W'(N_REQ);
            end
            if (!win_found_c && req[cand_c[IDX_W-1:0]]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c[IDX_W-1:0];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        gidx_d       = gidx_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        grant_d      = grant;
        tx_data_d    = tx_data;
        trmt_d       = 1'b0;
        byte_ack_d   = '0;
        burst_done_d = '0;

        case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    gidx_d             = win_idx_c;
                    grant_d            = '0;
                    grant_d[win_idx_c] = 1'b1;
                    cnt_d              = (len_lane[win_idx_c] == '0) ? LEN_W'(1)
                                                                     : len_lane[win_idx_c];
                    tx_data_d          = data_lane[win_idx_c];
                    trmt_d             = 1'b1;
                    byte_ack_d         = grant_d;
                    state_d            = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = GUARD;
            end
            GUARD: begin
                // tx_done is being cleared by the transmitter this cycle
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if ((cnt_q > LEN_W'(1)) && req[gidx_q]) begin
                        cnt_d      = cnt_q - LEN_W'(1);
                        tx_data_d  = data_lane[gidx_q];
                        trmt_d     = 1'b1;
                        byte_ack_d = grant;
                        state_d    = LAUNCH;
                    end else begin
                        burst_done_d = grant;
                        grant_d      = '0;
                        ptr_d        = (gidx_q == IDX_W'(N_REQ - 1)) ? '0
                                                                      : gidx_q + IDX_W'(1);
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any burst without burst_done
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gidx_q     <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant      <= '0;
            byte_ack   <= '0;
            burst_done <= '0;
            trmt       <= 1'b0;
            busy       <= 1'b0;
            tx_data    <= 8'h00;
        end else begin
            state_q    <= state_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            grant      <= grant_d;
            byte_ack   <= byte_ack_d;
            burst_done <= burst_done_d;
            trmt       <= trmt_d;
            busy       <= busy_d;
            tx_data    <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*LW-1:0] req_len;
    logic [N*8-1:0]  req_data;
    logic [N-1:0]    byte_ack;
    logic [N-1:0]    burst_done;
    logic [N-1:0]    grant;
    logic            busy;
    logic            trmt;
    logic [7:0]      tx_data;
    logic            tx_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bit fixed_frame = 1'b1;
    int fr_cnt;

    // Trace of observed transactions, appended by the compare process
    int         log_lane[$];
    logic [7:0] log_byte[$];
    int         log_done[$];

    uart_tx_arbiter #(.N_REQ(N), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_len    (req_len),
        .req_data   (req_data),
        .byte_ack   (byte_ack),
        .burst_done (burst_done),
        .grant      (grant),
        .busy       (busy),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    // UART transmitter stand-in: sticky done, cleared after trmt, set after the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_done <= 1'b1;
            fr_cnt  <= 0;
        end else if (trmt) begin
            tx_done <= 1'b0;
            fr_cnt  <= fixed_frame ? 8 : int'($urandom_range(10, 1));
        end else if (fr_cnt > 0) begin
            fr_cnt <= fr_cnt - 1;
            if (fr_cnt == 1) tx_done <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = N - 1; i >= 0; i--) if (v[i] === 1'b1) r = i;
        return r;
    endfunction

    // ---------------- reference model ----------------
    bit         m_valid = 1'b0;
    int         m_owner, m_ptr, m_left, m_last;
    logic [N-1:0] m_grant, m_ack, m_done;
    logic       m_trmt, m_busy;
    logic [7:0] m_tx;

    function automatic int eff_len(input int i);
        int v = int'(req_len[i*LW +: LW]);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic m_issue(input int o);
        m_tx       = req_data[o*8 +: 8];
        m_grant    = '0;
        m_grant[o] = 1'b1;
        m_ack      = m_grant;
        m_trmt     = 1'b1;
        m_busy     = 1'b1;
        m_last     = cyc + 1;
    endtask

    // Compare DUT against the model mid-cycle, then advance the model one cycle
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                check("grant",      32'(grant),      32'(m_grant));
                check("trmt",       32'(trmt),       32'(m_trmt));
                check("byte_ack",   32'(byte_ack),   32'(m_ack));
                check("burst_done", 32'(burst_done), 32'(m_done));
                check("busy",       32'(busy),       32'(m_busy));
                check("tx_data",    32'(tx_data),    32'(m_tx));
                if (trmt === 1'b1) begin
                    log_lane.push_back(oh_idx(grant));
                    log_byte.push_back(tx_data);
                end
                if (burst_done !== '0) log_done.push_back(oh_idx(burst_done));
            end
            m_trmt = 1'b0;
            m_ack  = '0;
            m_done = '0;
            if (rst === 1'b1) begin
                m_valid = 1'b1;
                m_owner = -1;
                m_ptr   = 0;
                m_left  = 0;
                m_last  = -100;
                m_grant = '0;
                m_busy  = 1'b0;
                m_tx    = 8'h00;
            end else if (m_valid) begin
                if (m_owner < 0) begin
                    for (int k = 0; k < N; k++)
                        if (m_owner < 0 && req[(m_ptr + k) % N] === 1'b1) m_owner = (m_ptr + k) % N;
                    if (m_owner >= 0) begin
                        m_left = eff_len(m_owner);
                        m_issue(m_owner);
                    end
                end else if (cyc >= m_last + 2 && tx_done === 1'b1) begin
                    if (m_left > 1 && req[m_owner] === 1'b1) begin
                        m_left--;
                        m_issue(m_owner);
                    end else begin
                        m_done          = '0;
                        m_done[m_owner] = 1'b1;
                        m_grant         = '0;
                        m_busy          = 1'b0;
                        m_ptr           = (m_owner + 1) % N;
                        m_owner         = -1;
                    end
                end
            end
            cyc++;
        end
    end

    // ---------------- requester behaviour ----------------
    logic [7:0]   lane_bytes [N][16];
    int           drop_after [N];
    int           acked      [N];
    logic [N-1:0] ack_prev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present the next byte the cycle after byte_ack; drop req after drop_after bytes
    task automatic service();
        for (int i = 0; i < N; i++) begin
            if (ack_prev[i] && req[i]) begin
                acked[i]++;
                if (acked[i] >= drop_after[i]) req[i] = 1'b0;
                else req_data[i*8 +: 8] = lane_bytes[i][acked[i] % 16];
            end
        end
        ack_prev = byte_ack;
    endtask

    task automatic setup_lane(input int i, input int lenf, input int drop,
                              input int first, input int step);
        for (int j = 0; j < 16; j++) lane_bytes[i][j] = 8'(first + step * j);
        drop_after[i]       = drop;
        acked[i]            = 0;
        req_len[i*LW +: LW] = LW'(lenf);
        req_data[i*8 +: 8]  = lane_bytes[i][0];
        req[i]              = 1'b1;
    endtask

    task automatic wait_done(input int lane, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            tick();
            service();
            if (burst_done[lane] === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int b_l, b_d, nd, lenf, eff, drop;
        int rr_exp[6];
        rr_exp = '{0, 1, 3, 0, 1, 3};

        rst = 1'b1; req = '0; req_len = '0; req_data = '0; ack_prev = '0;
        for (int i = 0; i < N; i++) begin drop_after[i] = 0; acked[i] = 0; end

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        repeat (20) begin tick(); service(); end
        check("idle_grant",   32'(grant),   32'(0));
        check("idle_trmt",    32'(trmt),    32'(0));
        check("idle_busy",    32'(busy),    32'(0));
        check("idle_tx_data", 32'(tx_data), 32'(0));

        // Round-robin with 1011 held; lane 1 length 0 means one byte
        b_l = log_lane.size(); b_d = log_done.size(); nd = 0;
        setup_lane(0, 1, 1000, 'h50, 1);
        setup_lane(1, 0, 1000, 'h60, 1);
        setup_lane(3, 1, 1000, 'h70, 1);
        for (int c = 0; c < 400 && nd < 6; c++) begin
            tick();
            service();
            if (burst_done !== '0) nd++;
            if (nd == 6) req = '0;
        end
        check("rr_six_bursts", 32'(nd), 32'(6));
        repeat (5) begin tick(); service(); end
        check("rr_idle_after", 32'(busy), 32'(0));
        for (int k = 0; k < 6; k++)
            check("rr_order", 32'((log_done.size() > b_d + k) ? log_done[b_d + k] : -1), 32'(rr_exp[k]));
        check("rr_nbytes", 32'(log_lane.size() - b_l), 32'(6));

        // Single byte on lane 2
        b_l = log_lane.size(); b_d = log_done.size();
        setup_lane(2, 1, 1, 'hA5, 0);
        tick();
        check("single_grant",    32'(grant),    32'(4'b0100));
        check("single_trmt",     32'(trmt),     32'(1));
        check("single_tx_data",  32'(tx_data),  32'(8'hA5));
        check("single_byte_ack", 32'(byte_ack), 32'(4'b0100));
        service();
        wait_done(2, 60, ok);
        check("single_done_seen", 32'(ok), 32'(1));
        check("single_grant_end", 32'(grant), 32'(0));
        tick(); service();
        check("single_nbytes", 32'(log_lane.size() - b_l), 32'(1));
        check("single_byte",   32'((log_byte.size() > b_l) ? log_byte[b_l] : 8'h00), 32'(8'hA5));
        check("single_done",   32'((log_done.size() > b_d) ? log_done[b_d] : -1), 32'(2));

        // Burst of 3 on lane 0 with data 11/22/33
        b_l = log_lane.size(); b_d = log_done.size();
        setup_lane(0, 3, 3, 'h11, 'h11);
        wait_done(0, 120, ok);
        check("burst_done_seen", 32'(ok), 32'(1));
        tick(); service();
        check("burst_nbytes", 32'(log_lane.size() - b_l), 32'(3));
        for (int k = 0; k < 3; k++) begin
            check("burst_byte", 32'((log_byte.size() > b_l + k) ? log_byte[b_l + k] : 8'h00),
                  32'(8'h11 * (k + 1)));
            check("burst_lane", 32'((log_lane.size() > b_l + k) ? log_lane[b_l + k] : -1), 32'(0));
        end
        check("burst_ndone", 32'(log_done.size() - b_d), 32'(1));

        // Abort: lane 1 asks for 5, drops req after byte 2 is captured
        b_l = log_lane.size(); b_d = log_done.size();
        setup_lane(1, 5, 2, 'h40, 1);
        wait_done(1, 150, ok);
        check("abort_done_seen", 32'(ok), 32'(1));
        check("abort_grant_end", 32'(grant), 32'(0));
        repeat (12) begin tick(); service(); end
        check("abort_nbytes", 32'(log_lane.size() - b_l), 32'(2));
        check("abort_ndone",  32'(log_done.size() - b_d), 32'(1));
        check("abort_byte2",  32'((log_byte.size() > b_l + 1) ? log_byte[b_l + 1] : 8'h00), 32'(8'h41));

        // Reset during the wait of byte 2
        b_l = log_lane.size(); b_d = log_done.size();
        setup_lane(2, 4, 4, 'h80, 1);
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            tick(); service();
            if (log_lane.size() >= b_l + 2) ok = 1'b1;
        end
        check("rstmid_second_byte", 32'(ok), 32'(1));
        tick(); service();
        tick(); service();
        check("rstmid_in_wait", 32'(busy), 32'(1));
        rst = 1'b1; req = '0; ack_prev = '0;
        tick();
        check("rstmid_grant", 32'(grant), 32'(0));
        check("rstmid_trmt",  32'(trmt),  32'(0));
        check("rstmid_busy",  32'(busy),  32'(0));
        rst = 1'b0;
        b_l = log_lane.size();
        setup_lane(3, 1, 1, 'hC3, 0);
        setup_lane(0, 1, 1, 'hC0, 0);
        wait_done(3, 120, ok);
        check("rstmid_lane3_done", 32'(ok), 32'(1));
        tick(); service();
        check("rstmid_first",  32'((log_lane.size() > b_l) ? log_lane[b_l] : -1), 32'(0));
        check("rstmid_second", 32'((log_lane.size() > b_l + 1) ? log_lane[b_l + 1] : -1), 32'(3));
        check("rstmid_ndone",  32'(log_done.size() - b_d), 32'(2));
        check("rstmid_no_lane2_done", 32'((log_done.size() > b_d) ? log_done[b_d] : -1), 32'(0));

        // Random traffic, random frame lengths, occasional aborts and resets
        fixed_frame = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (rst) rst = 1'b0;
            service();
            if ($urandom_range(399, 0) == 0) begin
                rst = 1'b1; req = '0; ack_prev = '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (!req[i] && !grant[i] && $urandom_range(7, 0) == 0) begin
                        lenf = int'($urandom_range(15, 0));
                        eff  = (lenf == 0) ? 1 : lenf;
                        drop = ($urandom_range(5, 0) == 0) ? int'($urandom_range(eff, 1)) : eff;
                        setup_lane(i, lenf, drop, int'($urandom_range(255, 0)),
                                   int'($urandom_range(255, 1)));
                    end
                end
            end
        end
        rst = 1'b0;
        req = '0;
        repeat (40) begin tick(); service(); end
        check("final_idle", 32'(busy), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
